wb_ibex_arbiter: RTL and testbench

Two-master to one-slave Wishbone B4 pipelined arbiter that shares a single bus between the Ibex instruction port and data port (each already converted to Wishbone by `core2wb`). It sits between `wb_ibex_top` and a single-ported memory or interconnect. It tracks outstanding transactions so that the grant never changes while responses are in flight. A hold limit guarantees that neither master starves the other.

---
 rtl/wb_ibex_arbiter_if.sv | 17 +
 rtl/wb_ibex_arbiter.sv | 169 ++++++++++++++++
 tb/tb_wb_ibex_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_ibex_arbiter_if.sv
// Wishbone B4 pipelined bus bundle shared by both Ibex-side masters and the arbitrated slave.
// The master modport drives the request fields; the slave modport drives the response fields.
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (output cyc, stb, we, sel, adr, dat_m, input dat_s, ack, err, stall);
  modport slave  (input cyc, stb, we, sel, adr, dat_m, output dat_s, ack, err, stall);
endinterface

// File: rtl/wb_ibex_arbiter.sv
// Two-master to one-slave Wishbone B4 pipelined arbiter for the Ibex instruction and data ports.
// Ownership is held while responses are in flight; a hold limit hands the bus over to a waiting master.
module wb_ibex_arbiter #(
  parameter bit          ROUND_ROBIN     = 1'b1,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned HOLD_MAX        = 16
) (
  input  logic       clk,
  input  logic       rst,
  wb_if.slave        m0_wb,
  wb_if.slave        m1_wb,
  wb_if.master       s_wb,
  output logic [1:0] gnt,
  output logic [3:0] outstanding
);

  localparam int unsigned HOLD_W   = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [3:0]  MAX_CNT  = 4'(MAX_OUTSTANDING);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);
  localparam bit          HOLD_EN  = (HOLD_MAX != 0);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t            state;
  state_t            state_next;
  state_t            other_state;
  logic              last;
  logic [3:0]        cnt;
  logic [HOLD_W-1:0] hold;

  logic own_cyc;
  logic own_stb;
  logic other_cyc;
  logic hold_expired;
  logic block;
  logic accept;
  logic resp_ok;
  logic resp_valid;

  // Owner / waiting-master views of the request lines
  always_comb begin
    own_cyc     = 1'b0;
    own_stb     = 1'b0;
    other_cyc   = 1'b0;
    other_state = OWN0;
    case (state)
      OWN0: begin
        own_cyc     = m0_wb.cyc;
        own_stb     = m0_wb.stb;
        other_cyc   = m1_wb.cyc;
        other_state = OWN1;
      end
      OWN1: begin
        own_cyc     = m1_wb.cyc;
        own_stb     = m1_wb.stb;
        other_cyc   = m0_wb.cyc;
        other_state = OWN0;
      end
      default: ;
    endcase
  end

  assign hold_expired = HOLD_EN && (hold >= HOLD_LIM) && other_cyc;
  assign block        = (cnt == MAX_CNT) || hold_expired;
  assign accept       = s_wb.stb && !s_wb.stall;
  assign resp_ok      = (state != IDLE) && (cnt != 4'd0);
  assign resp_valid   = resp_ok && (s_wb.ack || s_wb.err);

  assign gnt         = {state == OWN1, state == OWN0};
  assign outstanding = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: handover only when nothing is in flight
  always_comb begin
    state_next = state;
    if (state == IDLE) begin
      if (m0_wb.cyc && m1_wb.cyc) state_next = (!ROUND_ROBIN || !last) ? OWN1 : OWN0;
      else if (m0_wb.cyc)         state_next = OWN0;
      else if (m1_wb.cyc)         state_next = OWN1;
    end else begin
      if (!own_cyc)
        state_next = ((cnt == 4'd0) && other_cyc) ? other_state : IDLE;
      else if ((cnt == 4'd0) && hold_expired)
        state_next = other_state;
      else if (!own_stb && (cnt == 4'd0) && !other_cyc)
        state_next = IDLE;
    end
  end

  // Bus mux; spurious responses (count 0) are not forwarded
  always_comb begin
    s_wb.cyc     = 1'b0;
    s_wb.stb     = 1'b0;
    s_wb.we      = 1'b0;
    s_wb.sel     = 4'h0;
    s_wb.adr     = 32'h0;
    s_wb.dat_m   = 32'h0;
    m0_wb.stall  = 1'b1;
    m0_wb.ack    = 1'b0;
    m0_wb.err    = 1'b0;
    m0_wb.dat_s  = 32'h0;
    m1_wb.stall  = 1'b1;
    m1_wb.ack    = 1'b0;
    m1_wb.err    = 1'b0;
    m1_wb.dat_s  = 32'h0;
    case (state)
      OWN0: begin
        s_wb.cyc    = m0_wb.cyc;
        s_wb.stb    = m0_wb.stb && !block;
        s_wb.we     = m0_wb.we;
        s_wb.sel    = m0_wb.sel;
        s_wb.adr    = m0_wb.adr;
        s_wb.dat_m  = m0_wb.dat_m;
        m0_wb.stall = s_wb.stall || block;
        m0_wb.ack   = s_wb.ack && resp_ok;
        m0_wb.err   = s_wb.err && resp_ok;
        m0_wb.dat_s = s_wb.dat_s;
      end
      OWN1: begin
        s_wb.cyc    = m1_wb.cyc;
        s_wb.stb    = m1_wb.stb && !block;
        s_wb.we     = m1_wb.we;
        s_wb.sel    = m1_wb.sel;
        s_wb.adr    = m1_wb.adr;
        s_wb.dat_m  = m1_wb.dat_m;
        m1_wb.stall = s_wb.stall || block;
        m1_wb.ack   = s_wb.ack && resp_ok;
        m1_wb.err   = s_wb.err && resp_ok;
        m1_wb.dat_s = s_wb.dat_s;
      end
      default: ;
    endcase
  end

  // Outstanding count; an owner dropping cyc abandons its in-flight responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if ((state != IDLE) && !own_cyc) begin
      cnt <= 4'd0;
    end else begin
      case ({accept, resp_valid})
        2'b10:   cnt <= cnt + 4'd1;
        2'b01:   cnt <= cnt - 4'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Hold timer and last-owner memory for round-robin ties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
      last <= 1'b1;
    end else begin
      if (state_next != state)
        hold <= '0;
      else if ((state != IDLE) && (hold != HOLD_LIM))
        hold <= hold + 1'b1;
      if ((state_next == OWN0) && (state != OWN0)) last <= 1'b0;
      if ((state_next == OWN1) && (state != OWN1)) last <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_ibex_arbiter.sv
// Directed self-checking bench for wb_ibex_arbiter: round-robin instance plus a fixed-priority instance.
module tb_wb_ibex_arbiter;
  logic       clk;
  logic       rst;
  logic [1:0] gnt;
  logic [3:0] outstanding;
  logic [1:0] pgnt;
  logic [3:0] pout;
  logic       man_ack;
  logic       auto_ack;
  logic       auto_pend;
  int         checks;
  int         errors;

  wb_if m0 ();
  wb_if m1 ();
  wb_if s  ();
  wb_if p0 ();
  wb_if p1 ();
  wb_if ps ();

  wb_ibex_arbiter #(.ROUND_ROBIN(1'b1), .MAX_OUTSTANDING(4), .HOLD_MAX(16)) dut (
    .clk(clk), .rst(rst), .m0_wb(m0), .m1_wb(m1), .s_wb(s), .gnt(gnt), .outstanding(outstanding)
  );

  wb_ibex_arbiter #(.ROUND_ROBIN(1'b0), .MAX_OUTSTANDING(4), .HOLD_MAX(16)) dut_pri (
    .clk(clk), .rst(rst), .m0_wb(p0), .m1_wb(p1), .s_wb(ps), .gnt(pgnt), .outstanding(pout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: acks every accepted strobe one cycle later when enabled
  always @(posedge clk) auto_pend <= auto_ack && s.stb && !s.stall;
  assign s.ack = man_ack | auto_pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; man_ack = 1'b0; auto_ack = 1'b0; auto_pend = 1'b0;
    m0.cyc = 0; m0.stb = 0; m0.we = 0; m0.sel = 4'h0; m0.adr = 32'h0; m0.dat_m = 32'h0;
    m1.cyc = 0; m1.stb = 0; m1.we = 0; m1.sel = 4'h0; m1.adr = 32'h0; m1.dat_m = 32'h0;
    s.err = 0; s.stall = 0; s.dat_s = 32'h0;
    p0.cyc = 0; p0.stb = 0; p0.we = 0; p0.sel = 4'h0; p0.adr = 32'h0; p0.dat_m = 32'h0;
    p1.cyc = 0; p1.stb = 0; p1.we = 0; p1.sel = 4'h0; p1.adr = 32'h0; p1.dat_m = 32'h0;
    ps.ack = 0; ps.err = 0; ps.stall = 0; ps.dat_s = 32'h0;

    // Reset values
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_out", 32'(outstanding), 32'h0);
    chk("rst_scyc", 32'(s.cyc), 32'h0);
    chk("rst_sstb", 32'(s.stb), 32'h0);
    chk("rst_m0stall", 32'(m0.stall), 32'h1);
    chk("rst_m1stall", 32'(m1.stall), 32'h1);
    chk("rst_m0ack", 32'(m0.ack), 32'h0);
    chk("rst_pgnt", 32'(pgnt), 32'h0);
    rst = 1'b0;

    // First round-robin tie goes to m0, then direct handover to m1
    m0.cyc = 1; m1.cyc = 1;
    tick(); chk("tie1_first", 32'(gnt), 32'h1);
    m0.cyc = 0;
    tick(); chk("tie1_second", 32'(gnt), 32'h2);
    m1.cyc = 0;
    tick(); chk("tie1_idle", 32'(gnt), 32'h0);

    // Solo m0 read of 0x100, ack two cycles after the accept
    m0.cyc = 1; m0.stb = 1; m0.adr = 32'h100; m0.sel = 4'hf;
    #1;
    chk("rd_idle_scyc", 32'(s.cyc), 32'h0);
    chk("rd_idle_stall", 32'(m0.stall), 32'h1);
    tick();
    chk("rd_gnt", 32'(gnt), 32'h1);
    chk("rd_sadr", s.adr, 32'h100);
    chk("rd_sstb", 32'(s.stb), 32'h1);
    chk("rd_stall", 32'(m0.stall), 32'h0);
    tick();
    chk("rd_out1", 32'(outstanding), 32'h1);
    m0.stb = 0;
    tick();
    man_ack = 1; s.dat_s = 32'hdeadbeef;
    #1;
    chk("rd_ack", 32'(m0.ack), 32'h1);
    chk("rd_dat", m0.dat_s, 32'hdeadbeef);
    chk("rd_m1ack", 32'(m1.ack), 32'h0);
    tick();
    man_ack = 0; m0.cyc = 0;
    chk("rd_out0", 32'(outstanding), 32'h0);
    chk("rd_gnt_hold", 32'(gnt), 32'h1);
    tick(); chk("rd_idle", 32'(gnt), 32'h0);

    // m0 owned last, so the next tie goes to m1
    m0.cyc = 1; m1.cyc = 1;
    tick(); chk("tie2_first", 32'(gnt), 32'h2);
    m1.cyc = 0;
    tick(); chk("tie2_second", 32'(gnt), 32'h1);
    m0.cyc = 0;
    tick(); chk("tie2_idle", 32'(gnt), 32'h0);

    // m1 six back-to-back strobes against a limit of four outstanding
    m1.cyc = 1; m1.stb = 1; m1.we = 1; m1.adr = 32'h200; m1.sel = 4'hf;
    tick();
    chk("bst_gnt", 32'(gnt), 32'h2);
    chk("bst_we", 32'(s.we), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("bst_fill", 32'(outstanding), 32'(i));
    end
    chk("bst_gate_stb", 32'(s.stb), 32'h0);
    chk("bst_gate_stall", 32'(m1.stall), 32'h1);
    tick();
    chk("bst_sat", 32'(outstanding), 32'h4);
    man_ack = 1;
    #1;
    chk("bst_ack", 32'(m1.ack), 32'h1);
    chk("bst_ack_stall", 32'(m1.stall), 32'h1);
    tick();
    man_ack = 0;
    chk("bst_out3a", 32'(outstanding), 32'h3);
    chk("bst_unstall", 32'(m1.stall), 32'h0);
    tick(); chk("bst_out4b", 32'(outstanding), 32'h4);
    man_ack = 1;
    tick();
    man_ack = 0;
    chk("bst_out3b", 32'(outstanding), 32'h3);
    tick(); chk("bst_out4c", 32'(outstanding), 32'h4);
    m1.stb = 0; man_ack = 1;
    tick(); chk("bst_drain3", 32'(outstanding), 32'h3);
    tick(); chk("bst_drain2", 32'(outstanding), 32'h2);
    tick(); chk("bst_drain1", 32'(outstanding), 32'h1);
    man_ack = 0; s.err = 1;
    #1;
    chk("bst_err", 32'(m1.err), 32'h1);
    tick();
    s.err = 0;
    chk("bst_drain0", 32'(outstanding), 32'h0);
    m1.cyc = 0;
    tick(); chk("bst_idle", 32'(gnt), 32'h0);

    // m0 streams while m1 waits: forced handover after 16 owned cycles
    auto_ack = 1; m0.cyc = 1; m0.stb = 1; m0.we = 0;
    tick();
    chk("hld_gnt0", 32'(gnt), 32'h1);
    m1.cyc = 1; m1.stb = 1;
    for (int i = 1; i <= 15; i++) tick();
    chk("hld_c15_stall", 32'(m0.stall), 32'h0);
    tick();
    chk("hld_c16_stall", 32'(m0.stall), 32'h1);
    chk("hld_c16_sstb", 32'(s.stb), 32'h0);
    chk("hld_c16_out", 32'(outstanding), 32'h1);
    tick();
    chk("hld_c17_out", 32'(outstanding), 32'h0);
    chk("hld_c17_gnt", 32'(gnt), 32'h1);
    tick();
    chk("hld_c18_gnt", 32'(gnt), 32'h2);
    chk("hld_c18_m1stall", 32'(m1.stall), 32'h0);
    m0.cyc = 0; m0.stb = 0; m1.cyc = 0; m1.stb = 0; auto_ack = 0;
    tick(); chk("hld_idle", 32'(gnt), 32'h0);

    // m1 aborts with two outstanding; late acks are swallowed
    m1.cyc = 1; m1.stb = 1; m1.adr = 32'h300;
    tick(); tick(); tick();
    m1.stb = 0;
    chk("abt_out2", 32'(outstanding), 32'h2);
    m1.cyc = 0;
    tick();
    chk("abt_cleared", 32'(outstanding), 32'h0);
    chk("abt_gnt", 32'(gnt), 32'h0);
    man_ack = 1;
    #1;
    chk("abt_m1ack", 32'(m1.ack), 32'h0);
    chk("abt_m0ack", 32'(m0.ack), 32'h0);
    tick();
    chk("abt_out_stay", 32'(outstanding), 32'h0);
    chk("abt_m1ack2", 32'(m1.ack), 32'h0);
    man_ack = 0;

    // Reset during an m1 burst
    m1.cyc = 1; m1.stb = 1;
    tick(); tick();
    chk("rb_pre_out", 32'(outstanding), 32'h1);
    rst = 1;
    #1;
    chk("rb_gnt", 32'(gnt), 32'h0);
    chk("rb_out", 32'(outstanding), 32'h0);
    chk("rb_scyc", 32'(s.cyc), 32'h0);
    chk("rb_stall", 32'(m1.stall), 32'h1);
    tick();
    rst = 0; m1.cyc = 0; m1.stb = 0;
    tick(); chk("rb_idle", 32'(gnt), 32'h0);

    // Fixed priority: m1 always wins a tie
    p0.cyc = 1; p1.cyc = 1;
    tick(); chk("pri_first", 32'(pgnt), 32'h2);
    p1.cyc = 0;
    tick(); chk("pri_second", 32'(pgnt), 32'h1);
    p0.cyc = 0;
    tick(); chk("pri_idle", 32'(pgnt), 32'h0);
    p0.cyc = 1; p1.cyc = 1;
    tick(); chk("pri_again", 32'(pgnt), 32'h2);
    p0.cyc = 0; p1.cyc = 0;
    tick(); chk("pri_idle2", 32'(pgnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
